// File: rtl/serial_in_fifo.sv
// serial_in_fifo: UART 8N1 receiver feeding a show-ahead receive FIFO.
//
// Deserialises frames from uart_rx (idle high, LSB first, one stop bit) and
// buffers the bytes for the SFR read mux, which pops one byte per CPU read.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   uart_rx    asynchronous serial input, idle high
//   pop        one-cycle strobe, removes the head byte
//   clr_err    one-cycle strobe, clears overrun and frame_err
//   rd_data    head byte (registered, show-ahead), 8'h00 when empty
//   empty      FIFO holds no bytes
//   count      number of stored bytes, 0..FIFO_DEPTH
//   overrun    sticky, a received byte was dropped because the FIFO was full
//   frame_err  sticky, a stop bit was sampled low
module serial_in_fifo #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_rx,
   input  logic                          pop,
   input  logic                          clr_err,
   output logic [7:0]                    rd_data,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overrun,
   output logic                          frame_err
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [TW-1:0] BitLast  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] BitHalf  = TW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] DepthVal = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } rx_state_e;

   // ---------------------------------------------------------------------
   // Input synchroniser (reset to the idle level so reset never fakes a start)
   // ---------------------------------------------------------------------
   logic rx_meta_q, rx_s_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // ---------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------
   rx_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          push_req;
   logic          frame_err_set;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q + TW'(1);
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      push_req      = 1'b0;
      frame_err_set = 1'b0;
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (!rx_s_q) begin
               state_d = StStart;
            end
         end
         StStart: begin
            // Re-check the start bit at mid-bit to reject short glitches.
            if (timer_q == BitHalf) begin
               timer_d = '0;
               if (rx_s_q) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StData;
                  bit_idx_d = '0;
               end
            end
         end
         StData: begin
            // Timer was cleared at mid start bit, so each wrap lands mid-bit.
            if (timer_q == BitLast) begin
               timer_d            = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (timer_q == BitLast) begin
               timer_d = '0;
               if (rx_s_q) begin
                  push_req = 1'b1;
                  state_d  = StIdle;
               end else begin
                  frame_err_set = 1'b1;
                  state_d       = StBreak;
               end
            end
         end
         StBreak: begin
            // A held-low line (break) is reported once, then ignored until idle.
            timer_d = '0;
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Receive FIFO
   // ---------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          overrun_q, overrun_d;
   logic          frame_err_q, frame_err_d;
   logic          full, do_push, do_pop;

   always_comb begin
      full    = (count_q == DepthVal);
      do_pop  = pop && (count_q != '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_push = push_req && (!full || do_pop);

      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end

      // Next head: bypass the byte being written if it becomes the head.
      if (count_d == '0) begin
         rd_data_d = 8'h00;
      end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
         rd_data_d = shift_q;
      end else begin
         rd_data_d = mem_q[rd_ptr_d];
      end

      // Set wins over clear.
      overrun_d   = (overrun_q && !clr_err) || (push_req && !do_push);
      frame_err_d = (frame_err_q && !clr_err) || frame_err_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_data_q   <= 8'h00;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign rd_data   = rd_data_q;
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_in_fifo.sv
// tb_serial_in_fifo: directed bench for serial_in_fifo (CLKS_PER_BIT=16,
// FIFO_DEPTH=4). A vector table drives frames/pops/clears and checks all
// status outputs after each step; hand-written sequences cover glitches,
// breaks, push+pop while full and reset mid-frame.
module tb_serial_in_fifo;

   localparam int unsigned Cpb   = 16;
   localparam int unsigned Depth = 4;

   logic       clk;
   logic       rst;
   logic       uart_rx;
   logic       pop;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       empty;
   logic [2:0] count;
   logic       overrun;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   serial_in_fifo #(
      .CLKS_PER_BIT (Cpb),
      .FIFO_DEPTH   (Depth)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .pop       (pop),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .empty     (empty),
      .count     (count),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum logic [1:0] {OpSend, OpPop, OpClr} op_e;

   typedef struct {
      op_e        op;
      logic [7:0] data;
      logic [2:0] exp_count;
      logic [7:0] exp_rd;
      logic       exp_ov;
      logic       exp_fe;
   } vec_t;

   localparam int NumVec = 19;
   vec_t vecs [NumVec];

   // Advance n clock edges and settle 1ns past the last one.
   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Sends one 8N1 frame; the line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      hold(1);
      uart_rx = 1'b0;
      hold(Cpb);
      for (int b = 0; b < 8; b++) begin
         uart_rx = d[b];
         hold(Cpb);
      end
      uart_rx = stop;
      hold(Cpb);
   endtask

   task automatic do_pop();
      pop = 1'b1;
      hold(1);
      pop = 1'b0;
   endtask

   task automatic do_clr();
      clr_err = 1'b1;
      hold(1);
      clr_err = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic [2:0] c, input logic [7:0] rd,
                               input logic ov, input logic fe);
      check({tag, " count"}, 32'(count), 32'(c));
      check({tag, " empty"}, 32'(empty), 32'(c == 3'd0));
      check({tag, " rd_data"}, 32'(rd_data), 32'(rd));
      check({tag, " overrun"}, 32'(overrun), 32'(ov));
      check({tag, " frame_err"}, 32'(frame_err), 32'(fe));
   endtask

   initial begin
      //            op      data   cnt   rd     ov    fe
      vecs[0]  = '{OpSend, 8'hA5, 3'd1, 8'hA5, 1'b0, 1'b0};
      vecs[1]  = '{OpPop,  8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{OpSend, 8'h00, 3'd1, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{OpSend, 8'hFF, 3'd2, 8'h00, 1'b0, 1'b0};
      vecs[4]  = '{OpSend, 8'h3C, 3'd3, 8'h00, 1'b0, 1'b0};
      vecs[5]  = '{OpPop,  8'h00, 3'd2, 8'hFF, 1'b0, 1'b0};
      vecs[6]  = '{OpPop,  8'h00, 3'd1, 8'h3C, 1'b0, 1'b0};
      vecs[7]  = '{OpPop,  8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
      vecs[8]  = '{OpPop,  8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
      vecs[9]  = '{OpSend, 8'h01, 3'd1, 8'h01, 1'b0, 1'b0};
      vecs[10] = '{OpSend, 8'h02, 3'd2, 8'h01, 1'b0, 1'b0};
      vecs[11] = '{OpSend, 8'h03, 3'd3, 8'h01, 1'b0, 1'b0};
      vecs[12] = '{OpSend, 8'h04, 3'd4, 8'h01, 1'b0, 1'b0};
      vecs[13] = '{OpSend, 8'h05, 3'd4, 8'h01, 1'b1, 1'b0};
      vecs[14] = '{OpPop,  8'h00, 3'd3, 8'h02, 1'b1, 1'b0};
      vecs[15] = '{OpPop,  8'h00, 3'd2, 8'h03, 1'b1, 1'b0};
      vecs[16] = '{OpPop,  8'h00, 3'd1, 8'h04, 1'b1, 1'b0};
      vecs[17] = '{OpPop,  8'h00, 3'd0, 8'h00, 1'b1, 1'b0};
      vecs[18] = '{OpClr,  8'h00, 3'd0, 8'h00, 1'b0, 1'b0};

      rst     = 1'b1;
      uart_rx = 1'b1;
      pop     = 1'b0;
      clr_err = 1'b0;
      hold(3);
      rst = 1'b0;
      hold(1);
      check_status("reset", 3'd0, 8'h00, 1'b0, 1'b0);

      // Table-driven frames, pops and clears.
      for (int i = 0; i < NumVec; i++) begin
         unique case (vecs[i].op)
            OpSend:  send_frame(vecs[i].data, 1'b1);
            OpPop:   do_pop();
            default: do_clr();
         endcase
         check_status($sformatf("row%0d", i), vecs[i].exp_count, vecs[i].exp_rd,
                      vecs[i].exp_ov, vecs[i].exp_fe);
      end

      // Short low glitch must be rejected at the mid start-bit check.
      uart_rx = 1'b0;
      hold(4);
      uart_rx = 1'b1;
      hold(40);
      check_status("glitch", 3'd0, 8'h00, 1'b0, 1'b0);

      // Stop bit low, line then held low: one frame_err, no bytes.
      send_frame(8'h55, 1'b0);
      hold(40);
      check_status("break set", 3'd0, 8'h00, 1'b0, 1'b1);
      do_clr();
      hold(50);
      check("break no reset", 32'(frame_err), 32'(1'b0));
      uart_rx = 1'b1;
      hold(20);
      check_status("break end", 3'd0, 8'h00, 1'b0, 1'b0);

      // Fill the FIFO, then pop in the exact cycle the 8'h77 push happens
      // (stop-bit sample 156 edges after the start bit is driven).
      send_frame(8'h10, 1'b1);
      send_frame(8'h11, 1'b1);
      send_frame(8'h12, 1'b1);
      send_frame(8'h13, 1'b1);
      check_status("full", 3'd4, 8'h10, 1'b0, 1'b0);
      fork
         send_frame(8'h77, 1'b1);
         begin
            hold(1);
            hold(155);
            pop = 1'b1;
            hold(1);
            pop = 1'b0;
         end
      join
      check_status("full push+pop", 3'd4, 8'h11, 1'b0, 1'b0);
      do_pop();
      check("drain1 rd", 32'(rd_data), 32'h12);
      do_pop();
      check("drain2 rd", 32'(rd_data), 32'h13);
      do_pop();
      check("drain3 rd", 32'(rd_data), 32'h77);
      do_pop();
      check_status("drained", 3'd0, 8'h00, 1'b0, 1'b0);

      // Reset in the middle of a frame's data bits.
      send_frame(8'h42, 1'b1);
      check_status("pre-rst", 3'd1, 8'h42, 1'b0, 1'b0);
      uart_rx = 1'b0;
      hold(Cpb);
      uart_rx = 1'b1;
      hold(Cpb);
      uart_rx = 1'b0;
      hold(10);
      rst     = 1'b1;
      uart_rx = 1'b1;
      hold(2);
      rst = 1'b0;
      hold(1);
      check_status("mid-rst", 3'd0, 8'h00, 1'b0, 1'b0);
      hold(20);
      send_frame(8'h81, 1'b1);
      check_status("post-rst", 3'd1, 8'h81, 1'b0, 1'b0);
      do_pop();
      check_status("post-rst pop", 3'd0, 8'h00, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
